ctrl_ramdrv_tap_reader: RTL

//  Read-side companion of the per-channel header table: fetches a channel's head offset
//  (drives head_read/head_index, captures head_offset) and streams the channel's ring-buffer

---
 rtl/ctrl_ramdrv_tap_reader.sv | 138 +++++++++++++
 1 files changed

// File: rtl/ctrl_ramdrv_tap_reader.sv
// ctrl_ramdrv_tap_reader
//   Read-side companion of the per-channel header table. On start it fetches
//   the channel's head offset, then streams ring-buffer read addresses
//   newest-to-oldest (wrapping 0 -> len_reg) for one FIR convolution pass,
//   handshaking with the sample RAM read port via rd_valid/rd_ready.
//
//   Optional feature macro: TAP_READER_COEF_ADDR_EN
//     When defined, adds output coef_addr = tap number (0 = newest sample)
//     during STREAM, 0 otherwise.
module ctrl_ramdrv_tap_reader #(
    parameter int OFFSET_WIDTH = 10,
    parameter int INDEX_WIDTH  = 4
) (
    input  logic                                clk,
    input  logic                                clr,
    input  logic                                init,
    input  logic [OFFSET_WIDTH-1:0]             length,
    input  logic                                start,
    input  logic [INDEX_WIDTH-1:0]              index,
    output logic                                head_read,
    output logic [INDEX_WIDTH-1:0]              head_index,
    input  logic [OFFSET_WIDTH-1:0]             head_offset,
    output logic                                rd_valid,
    input  logic                                rd_ready,
    output logic [INDEX_WIDTH+OFFSET_WIDTH-1:0] rd_addr,
    output logic                                rd_last,
    output logic                                busy,
`ifdef TAP_READER_COEF_ADDR_EN
    output logic [OFFSET_WIDTH-1:0]             coef_addr,
`endif
    output logic                                done
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FETCH  = 2'd1,
        S_STREAM = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t                  state_reg;
    logic [OFFSET_WIDTH-1:0] len_reg;
    logic [INDEX_WIDTH-1:0]  idx_reg;
    logic [OFFSET_WIDTH-1:0] ptr_reg;
    logic [OFFSET_WIDTH-1:0] cnt_reg;
    logic                    head_read_reg;
    logic                    rd_valid_reg;
    logic                    rd_last_reg;
    logic                    busy_reg;
    logic                    done_reg;

    logic                    accept;
    logic [OFFSET_WIDTH-1:0] cnt_next;
    logic [OFFSET_WIDTH-1:0] ptr_next;

    // Beat handshake and the next tap position (newest-to-oldest with wrap)
    always_comb begin
        accept   = rd_valid_reg & rd_ready;
        cnt_next = cnt_reg + OFFSET_WIDTH'(1);
        ptr_next = (ptr_reg == '0) ? len_reg : ptr_reg - OFFSET_WIDTH'(1);
    end

    // Controller FSM with registered handshake/status outputs
    always_ff @(posedge clk) begin
        if (clr) begin
            state_reg     <= S_IDLE;
            len_reg       <= '0;
            idx_reg       <= '0;
            ptr_reg       <= '0;
            cnt_reg       <= '0;
            head_read_reg <= 1'b0;
            rd_valid_reg  <= 1'b0;
            rd_last_reg   <= 1'b0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    // init wins over a coincident start; that start is dropped
                    if (init) begin
                        len_reg <= length;
                    end else if (start) begin
                        idx_reg       <= index;
                        head_read_reg <= 1'b1;
                        busy_reg      <= 1'b1;
                        state_reg     <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    // Head offset is taken as-is, even if beyond len_reg;
                    // cnt alone bounds the pass length.
                    ptr_reg       <= head_offset;
                    cnt_reg       <= '0;
                    head_read_reg <= 1'b0;
                    rd_valid_reg  <= 1'b1;
                    rd_last_reg   <= (len_reg == '0);
                    state_reg     <= S_STREAM;
                end
                S_STREAM: begin
                    if (accept) begin
                        if (rd_last_reg) begin
                            rd_valid_reg <= 1'b0;
                            rd_last_reg  <= 1'b0;
                            done_reg     <= 1'b1;
                            state_reg    <= S_DONE;
                        end else begin
                            ptr_reg     <= ptr_next;
                            cnt_reg     <= cnt_next;
                            rd_last_reg <= (cnt_next == len_reg);
                        end
                    end
                end
                S_DONE: begin
                    done_reg  <= 1'b0;
                    busy_reg  <= 1'b0;
                    state_reg <= S_IDLE;
                end
                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

    assign head_read  = head_read_reg;
    assign head_index = idx_reg;
    assign rd_valid   = rd_valid_reg;
    assign rd_addr    = {idx_reg, ptr_reg};
    assign rd_last    = rd_last_reg;
    assign busy       = busy_reg;
    assign done       = done_reg;

`ifdef TAP_READER_COEF_ADDR_EN
    // Tap number tracks cnt while streaming, parked at 0 elsewhere
    assign coef_addr = rd_valid_reg ? cnt_reg : '0;
`endif

endmodule
